// File: rtl/dnn_pkg.sv
// dnn_pkg: shared types, fp16 constants and fp16 arithmetic helpers for the dense layer engine.
package dnn_pkg;
   typedef enum logic [1:0] {ACT_NONE, ACT_RELU, ACT_RELU6, ACT_RSVD} act_mode_t;
   typedef enum logic [2:0] {S_IDLE, S_MAC, S_MAC_DRAIN, S_BIAS_REQ, S_BIAS_ADD, S_ACT, S_EMIT, S_DONE} state_t;
   localparam logic [15:0] FP16_ZERO = 16'h0000;
   localparam logic [15:0] FP16_SIX  = 16'h4600;
   localparam logic [15:0] FP16_NAN  = 16'h7E00;

   // Subnormal operands and results flush to signed zero; rounding is nearest-even.
   function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
      logic s;
      logic [21:0] p;
      logic [10:0] mg;
      logic st;
      int e;
      logic [15:0] r;
      s = a[15] ^ b[15];
      if ((&a[14:10] && |a[9:0]) || (&b[14:10] && |b[9:0])) return FP16_NAN;
      if (&a[14:10] || &b[14:10])
         return (a[14:10] == 5'd0 || b[14:10] == 5'd0) ? FP16_NAN : {s, 5'h1f, 10'd0};
      if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
      p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
      e = int'(a[14:10]) + int'(b[14:10]) - 15 + int'(p[21]);
      mg = p[21] ? p[20:10] : p[19:9];
      st = p[21] ? |p[9:0] : |p[8:0];
      if (e <= 0) return {s, 15'd0};
      if (e >= 31) return {s, 5'h1f, 10'd0};
      r = {1'b0, e[4:0], mg[10:1]} + {15'd0, mg[0] & (st | mg[1])};
      return {s, r[14:0]};
   endfunction

   // Aligned sum is exact in 64 bits, so a single rounding step follows normalisation.
   function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] a, b, r;
      logic [63:0] ma, mb, sm, rs;
      logic [9:0] m;
      logic g, st;
      int d, k, e;
      a = (x[14:0] >= y[14:0]) ? x : y;
      b = (x[14:0] >= y[14:0]) ? y : x;
      if (&a[14:10]) return (|a[9:0] || (&b[14:10] && a[15] != b[15])) ? FP16_NAN : a;
      if (b[14:10] == 5'd0) return (a[14:10] == 5'd0) ? {a[15] & b[15], 15'd0} : a;
      d = int'(a[14:10]) - int'(b[14:10]);
      ma = {13'd0, 1'b1, a[9:0], 40'd0};
      mb = {13'd0, 1'b1, b[9:0], 40'd0} >> d;
      sm = (a[15] == b[15]) ? ma + mb : ma - mb;
      if (sm == 64'd0) return FP16_ZERO;
      k = 0;
      for (int j = 0; j < 64; j++) if (|(sm >> j)) k = j;
      e = int'(a[14:10]) + k - 50;
      m = 10'(sm >> (k - 10));
      rs = sm >> (k - 11);
      g = rs[0];
      st = |(sm & ((64'd1 << (k - 11)) - 64'd1));
      if (e <= 0) return {a[15], 15'd0};
      if (e >= 31) return {a[15], 5'h1f, 10'd0};
      r = {1'b0, e[4:0], m} + {15'd0, g & (st | m[0])};
      return {a[15], r[14:0]};
   endfunction

   function automatic logic [15:0] fp16_act(input act_mode_t md, input logic [15:0] x);
      if ((md == ACT_RELU || md == ACT_RELU6) && x[15]) return FP16_ZERO;
      return (md == ACT_RELU6 && x > FP16_SIX) ? FP16_SIX : x;
   endfunction
endpackage

// File: rtl/fp16_mac_lane.sv
// fp16_mac_lane: one output neuron's product register, accumulator, bias add and activation.
module float_adder import dnn_pkg::*; (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum
);
   assign sum = fp16_add(a, b);
endmodule

module fp16_mac_lane import dnn_pkg::*; (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] in_data,
   input  logic [15:0] w_data,
   input  logic [15:0] b_data,
   input  act_mode_t   mode,
   input  logic        clr,
   input  logic        mul_en,
   input  logic        acc_en,
   input  logic        bias_en,
   input  logic        act_en,
   output logic [15:0] acc
);
   logic [15:0] prod, sum;
   // One adder serves both the MAC accumulate and the bias add.
   float_adder u_add (.a(acc), .b(bias_en ? b_data : prod), .sum(sum));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         prod <= FP16_ZERO;
         acc  <= FP16_ZERO;
      end else begin
         if (mul_en) prod <= fp16_mul(in_data, w_data);
         acc <= clr ? FP16_ZERO : (acc_en || bias_en) ? sum : act_en ? fp16_act(mode, acc) : acc;
      end
endmodule

// File: rtl/dense_layer_stream.sv
// dense_layer_stream: tiled fp16 fully-connected layer, LANES neurons per tile, streamed operands
// and a valid/ready result stream.
module dense_layer_stream import dnn_pkg::*; #(
   parameter  int IN_N  = 60,
   parameter  int OUT_N = 50,
   parameter  int LANES = 10,
   localparam int NT = (OUT_N + LANES - 1) / LANES,
   localparam int AW = IN_N > 1 ? $clog2(IN_N) : 1,
   localparam int TW = NT > 1 ? $clog2(NT) : 1,
   localparam int OW = OUT_N > 1 ? $clog2(OUT_N) : 1,
   localparam int LW = LANES > 1 ? $clog2(LANES) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            act_mode,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [AW-1:0]         in_addr,
   output logic [TW-1:0]         w_tile,
   input  logic [15:0]           in_rdata,
   input  logic [LANES*16-1:0]   w_rdata,
   output logic                  b_rd_en,
   input  logic [LANES*16-1:0]   b_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OW-1:0]         out_idx,
   output logic [15:0]           out_data
);
   localparam int LAST_V = OUT_N - (NT - 1) * LANES;
   state_t state, nxt;
   act_mode_t mode;
   logic [AW-1:0] i;
   logic [TW-1:0] t;
   logic [LW-1:0] ln;
   logic dc, d1, d2, fire, last, last_t, clr;
   logic [15:0] res [LANES];

   assign fire      = out_valid && out_ready;
   assign last_t    = int'(t) == NT - 1;
   assign last      = int'(ln) == (last_t ? LAST_V : LANES) - 1;
   assign clr       = (state == S_IDLE && start) || (state == S_EMIT && fire && last && !last_t);
   assign busy      = state != S_IDLE;
   assign done      = state == S_DONE;
   assign rd_en     = state == S_MAC;
   assign b_rd_en   = state == S_BIAS_REQ;
   assign out_valid = state == S_EMIT;
   assign in_addr   = i;
   assign w_tile    = t;
   assign out_idx   = out_valid ? OW'(int'(t) * LANES + int'(ln)) : '0;
   assign out_data  = out_valid ? res[ln] : FP16_ZERO;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:      if (start) nxt = S_MAC;
         S_MAC:       if (int'(i) == IN_N - 1) nxt = S_MAC_DRAIN;
         S_MAC_DRAIN: if (dc) nxt = S_BIAS_REQ;
         S_BIAS_REQ:  nxt = S_BIAS_ADD;
         S_BIAS_ADD:  nxt = S_ACT;
         S_ACT:       nxt = S_EMIT;
         S_EMIT:      if (fire && last) nxt = last_t ? S_DONE : S_MAC;
         default:     nxt = S_IDLE;
      endcase
   end

   // d1/d2 mark cycles where read data and registered products are valid in the lanes.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mode <= ACT_NONE;
         i    <= '0;
         t    <= '0;
         ln   <= '0;
         dc   <= 1'b0;
         d1   <= 1'b0;
         d2   <= 1'b0;
      end else begin
         d1 <= rd_en;
         d2 <= d1;
         if (state == S_IDLE && start) begin
            mode <= act_mode_t'(act_mode);
            t    <= '0;
         end
         i  <= (state == S_MAC && int'(i) != IN_N - 1) ? i + 1'b1 : '0;
         dc <= state == S_MAC_DRAIN && !dc;
         if (fire) ln <= last ? '0 : ln + 1'b1;
         if (fire && last && !last_t) t <= t + 1'b1;
      end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      fp16_mac_lane u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .in_data (in_rdata),
         .w_data  (w_rdata[g*16 +: 16]),
         .b_data  (b_rdata[g*16 +: 16]),
         .mode    (mode),
         .clr     (clr),
         .mul_en  (d1),
         .acc_en  (d2),
         .bias_en (state == S_BIAS_ADD),
         .act_en  (state == S_ACT),
         .acc     (res[g])
      );
   end
endmodule

// File: tb/tb_dense_layer_stream.sv
// tb_dense_layer_stream: scoreboard bench; expected beats come from a real-valued layer model
// over operands chosen so every partial sum is exactly representable in fp16.
module tb_dense_layer_stream;
   localparam int IN_N = 4, OUT_N = 3, LANES = 2, NT = 2, AW = 2, TW = 1, OW = 2;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1;
   logic [1:0] act_mode = 2'd0;
   logic busy, done, rd_en, b_rd_en, out_valid;
   logic [AW-1:0] in_addr;
   logic [TW-1:0] w_tile;
   logic [15:0] in_rdata = '0;
   logic [LANES*16-1:0] w_rdata = '0, b_rdata = '0;
   logic [OW-1:0] out_idx;
   logic [15:0] out_data;

   int checks = 0, failures = 0;
   logic [15:0] inp [IN_N];
   logic [15:0] wt  [OUT_N*IN_N];
   logic [15:0] bs  [OUT_N];
   real inr [IN_N];
   real wr  [OUT_N*IN_N];
   real br  [OUT_N];
   logic [15:0] vc [7] = '{16'h0000, 16'h3C00, 16'hBC00, 16'h4000, 16'hC000, 16'h3800, 16'hB800};
   real         vr [7] = '{0.0, 1.0, -1.0, 2.0, -2.0, 0.5, -0.5};
   logic [15:0] bc [5] = '{16'h0000, 16'h3800, 16'hBC00, 16'h4200, 16'hC200};
   real         bv [5] = '{0.0, 0.5, -1.0, 3.0, -3.0};

   typedef struct {int idx; logic [15:0] data;} beat_t;
   beat_t sb [$];
   bit rand_bp = 1'b0, stall_arm = 1'b0, held = 1'b0;
   int stall_cnt = 0;
   logic [OW-1:0] hidx;
   logic [15:0] hdata;

   always #5 clk = ~clk;

   dense_layer_stream #(.IN_N(IN_N), .OUT_N(OUT_N), .LANES(LANES)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .act_mode(act_mode), .busy(busy), .done(done),
      .rd_en(rd_en), .in_addr(in_addr), .w_tile(w_tile), .in_rdata(in_rdata), .w_rdata(w_rdata),
      .b_rd_en(b_rd_en), .b_rdata(b_rdata), .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_data(out_data)
   );

   // Synchronous-read memories; lanes past OUT_N return garbage on purpose.
   always @(posedge clk) begin
      int o;
      for (int l = 0; l < LANES; l++) begin
         o = int'(w_tile) * LANES + l;
         if (rd_en) w_rdata[l*16 +: 16] <= (o < OUT_N) ? wt[o*IN_N + int'(in_addr)] : 16'($urandom);
         if (b_rd_en) b_rdata[l*16 +: 16] <= (o < OUT_N) ? bs[o] : 16'($urandom);
      end
      if (rd_en) in_rdata <= inp[in_addr];
   end

   always @(posedge clk) begin
      #2;
      if (stall_cnt > 0) begin
         out_ready = 1'b0;
         stall_cnt--;
      end else out_ready = rand_bp ? ($urandom_range(3) != 0) : 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) held = 1'b0;
      else begin
         if (held) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_idx", 32'(out_idx), 32'(hidx));
            check("hold_data", 32'(out_data), 32'(hdata));
         end
         held = out_valid && !out_ready;
         hidx = out_idx;
         hdata = out_data;
         if (out_valid && out_ready) begin
            beat_t e;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat idx=%0d data=%h required=no_beat", out_idx, out_data);
            end else begin
               e = sb.pop_front();
               check("beat_idx", 32'(out_idx), 32'(e.idx));
               check("beat_data", 32'(out_data), 32'(e.data));
            end
            if (stall_arm) begin
               stall_cnt = 5;
               stall_arm = 1'b0;
            end
         end
      end
   end

   function automatic logic [15:0] to_fp16(input real v);
      logic s;
      int e, m;
      if (v == 0.0) return 16'h0000;
      s = v < 0.0;
      if (s) v = -v;
      e = 15;
      while (v >= 2.0) begin v = v / 2.0; e++; end
      while (v < 1.0) begin v = v * 2.0; e--; end
      m = $rtoi((v - 1.0) * 1024.0);
      return {s, 5'(e), 10'(m)};
   endfunction

   function automatic real act_ref(input real v, input int md);
      if ((md == 1 || md == 2) && v < 0.0) return 0.0;
      if (md == 2 && v > 6.0) return 6.0;
      return v;
   endfunction

   task automatic fill_const(input logic [15:0] ic, input real iv, input logic [15:0] wc, input real wv,
                             input logic [15:0] bcc, input real bvv);
      for (int k = 0; k < IN_N; k++) begin inp[k] = ic; inr[k] = iv; end
      for (int k = 0; k < OUT_N*IN_N; k++) begin wt[k] = wc; wr[k] = wv; end
      for (int k = 0; k < OUT_N; k++) begin bs[k] = bcc; br[k] = bvv; end
   endtask

   task automatic fill_rand();
      int r;
      for (int k = 0; k < IN_N; k++) begin r = $urandom_range(6); inp[k] = vc[r]; inr[k] = vr[r]; end
      for (int k = 0; k < OUT_N*IN_N; k++) begin r = $urandom_range(6); wt[k] = vc[r]; wr[k] = vr[r]; end
      for (int k = 0; k < OUT_N; k++) begin r = $urandom_range(4); bs[k] = bc[r]; br[k] = bv[r]; end
   endtask

   task automatic run_pass(input int md, input bit chk_cyc, input bit disturb);
      int cyc = 0, exp_cyc = 0;
      real s;
      for (int o = 0; o < OUT_N; o++) begin
         s = br[o];
         for (int k = 0; k < IN_N; k++) s += inr[k] * wr[o*IN_N + k];
         sb.push_back('{o, to_fp16(act_ref(s, md))});
      end
      for (int t = 0; t < NT; t++) exp_cyc += IN_N + 5 + ((OUT_N - t*LANES < LANES) ? OUT_N - t*LANES : LANES);
      @(negedge clk);
      start = 1'b1;
      act_mode = 2'(md);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      for (int n = 0; n < 3000 && !done; n++) begin
         if (busy) cyc++;
         if (disturb && n == 3) begin
            start = 1'b1;
            act_mode = 2'(md ^ 3);
         end
         @(negedge clk);
      end
      check("done_seen", 32'(done), 32'd1);
      start = 1'b0;
      act_mode = 2'(md);
      if (chk_cyc) check("pass_cycles", 32'(cyc), 32'(exp_cyc));
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_fall", 32'(busy), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);
      repeat (8) @(negedge clk);
      check("idle_after_pass", 32'(busy), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
      check({tag, "_b_rd_en"}, 32'(b_rd_en), 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_in_addr"}, 32'(in_addr), 32'd0);
      check({tag, "_w_tile"}, 32'(w_tile), 32'd0);
      check({tag, "_out_idx"}, 32'(out_idx), 32'd0);
      check({tag, "_out_data"}, 32'(out_data), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      fill_const(16'h3C00, 1.0, 16'h3C00, 1.0, 16'h0000, 0.0);
      run_pass(0, 1'b1, 1'b0);
      fill_const(16'h3C00, 1.0, 16'hBC00, -1.0, 16'h0000, 0.0);
      run_pass(1, 1'b1, 1'b0);
      run_pass(0, 1'b1, 1'b0);
      fill_const(16'h3C00, 1.0, 16'h4000, 2.0, 16'h0000, 0.0);
      run_pass(2, 1'b1, 1'b0);
      run_pass(1, 1'b1, 1'b0);
      fill_const(16'h0000, 0.0, 16'h4000, 2.0, 16'h3800, 0.5);
      run_pass(0, 1'b1, 1'b0);
      fill_rand();
      stall_arm = 1'b1;
      run_pass(0, 1'b0, 1'b0);
      fill_rand();
      run_pass(1, 1'b0, 1'b1);
      fill_rand();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid_mac");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("idle_after_reset", 32'(busy), 32'd0);
      run_pass(2, 1'b1, 1'b0);
      rand_bp = 1'b1;
      for (int r = 0; r < 20; r++) begin
         fill_rand();
         run_pass(int'($urandom_range(3)), 1'b0, 1'b0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
